// File: rtl/interface_output.sv
// Output packer for the CORDIC core: buffers core results, undoes the input quadrant fold and
// serializes each result as one (arctan) or two (cos, sin) 32-bit words over valid/ready.
module interface_output #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      x_out,
    input  logic [DATA_WIDTH-1:0]      y_out,
    input  logic [DATA_WIDTH-1:0]      degree_out,
    input  logic                       flip_out,
    input  logic                       flip_dir_out,
    input  logic                       arctan_en_out,
    input  logic                       valid_out,
    output logic [31:0]                out_interface,
    output logic                       valid_out_interface,
    input  logic                       ready_in_interface,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
    output logic                       overflow_flag
);

    localparam int unsigned EntryWidth = 3 * DATA_WIDTH + 3;
    localparam int unsigned DepthInt = FIFO_DEPTH;
    localparam logic [FIFO_ADDR_WIDTH:0] FullCount = DepthInt[FIFO_ADDR_WIDTH:0];

    typedef enum logic {StIdle, StSin} state_e;

    state_e                     state_q, state_d;
    logic [EntryWidth-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wptr_q, rptr_q;
    logic [FIFO_ADDR_WIDTH:0]   count_q;
    logic                       ovf_q;
    logic [31:0]                out_q, out_d;
    logic                       valid_q, valid_d;

    logic                  push, pop, advance, empty, full;
    logic [DATA_WIDTH-1:0] h_x, h_y, h_deg, cos_val, sin_val, beat0_data;
    logic                  h_flip, h_dir, h_arc;

    function automatic logic [DATA_WIDTH-1:0] neg_sat(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] most_neg;
        most_neg = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        if (v == most_neg) begin
            return {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end
        return ~v + 1'b1;
    endfunction

    function automatic logic [31:0] pack_word(input logic beat, input logic arc,
                                              input logic [DATA_WIDTH-1:0] data);
        return {{(30 - DATA_WIDTH){1'b0}}, beat, arc, data};
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign advance = !valid_q || ready_in_interface;

    assign {h_x, h_y, h_deg, h_flip, h_dir, h_arc} = mem[rptr_q];

    // Undo the +/-90 degree fold applied at the input side of the core.
    always_comb begin
        cos_val = h_x;
        sin_val = h_y;
        if (h_flip) begin
            if (h_dir) begin
                cos_val = neg_sat(h_y);
                sin_val = h_x;
            end else begin
                cos_val = h_y;
                sin_val = neg_sat(h_x);
            end
        end
    end

    assign beat0_data = h_arc ? h_deg : cos_val;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        pop     = 1'b0;
        if (advance) begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        out_d   = pack_word(1'b0, h_arc, beat0_data);
                        valid_d = 1'b1;
                        if (h_arc) begin
                            pop = 1'b1;
                        end else begin
                            state_d = StSin;
                        end
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                StSin: begin
                    out_d   = pack_word(1'b1, 1'b0, sin_val);
                    valid_d = 1'b1;
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end
    end

    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push = valid_out && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= {x_out, y_out, degree_out, flip_out, flip_dir_out, arctan_en_out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (valid_out && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out_interface       = out_q;
    assign valid_out_interface = valid_q;
    assign fifo_count          = count_q;
    assign overflow_flag       = ovf_q;

endmodule

// File: tb/tb_interface_output.sv
// Self-checking bench for interface_output: directed scenarios plus randomized traffic checked
// against a queue-level reference model of the result stream.
module tb_interface_output;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] x_out, y_out, degree_out;
    logic        flip_out, flip_dir_out, arctan_en_out, valid_out, ready_in_interface;
    logic [31:0] out_interface;
    logic        valid_out_interface, overflow_flag;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    interface_output #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(4),
        .FIFO_ADDR_WIDTH(2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .x_out              (x_out),
        .y_out              (y_out),
        .degree_out         (degree_out),
        .flip_out           (flip_out),
        .flip_dir_out       (flip_dir_out),
        .arctan_en_out      (arctan_en_out),
        .valid_out          (valid_out),
        .out_interface      (out_interface),
        .valid_out_interface(valid_out_interface),
        .ready_in_interface (ready_in_interface),
        .fifo_count         (fifo_count),
        .overflow_flag      (overflow_flag)
    );

    typedef struct {
        logic [15:0] x, y, d;
        bit          flip, dir, arc;
    } res_t;

    res_t        q[$];
    bit          m_valid, m_pending, m_ovf;
    logic [31:0] m_out;

    function automatic logic [15:0] neg_sat(logic [15:0] v);
        int n;
        n = -int'($signed(v));
        if (n > 32767) n = 32767;
        return 16'(n);
    endfunction

    function automatic logic [31:0] word_of(res_t r, bit beat);
        logic [15:0] c, s;
        if (r.arc) return {16'h0001, r.d};
        if (!r.flip) begin c = r.x; s = r.y; end
        else if (r.dir) begin c = neg_sat(r.y); s = r.x; end
        else begin c = r.y; s = neg_sat(r.x); end
        return beat ? {16'h0002, s} : {16'h0000, c};
    endfunction

    // One clock edge: update the model from the inputs seen at the edge, then settle.
    task automatic step();
        res_t r;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_valid = 0; m_pending = 0; m_ovf = 0; m_out = '0;
        end else begin
            if (!m_valid || ready_in_interface) begin
                if (m_pending) begin
                    m_out = word_of(q[0], 1'b1);
                    m_valid = 1;
                    m_pending = 0;
                    void'(q.pop_front());
                end else if (q.size() > 0) begin
                    m_out = word_of(q[0], 1'b0);
                    m_valid = 1;
                    if (q[0].arc) void'(q.pop_front());
                    else m_pending = 1;
                end else begin
                    m_valid = 0;
                end
            end
            if (valid_out) begin
                if (q.size() < 4) begin
                    r.x = x_out; r.y = y_out; r.d = degree_out;
                    r.flip = flip_out; r.dir = flip_dir_out; r.arc = arctan_en_out;
                    q.push_back(r);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        #1;
    endtask

    task automatic drive(bit v, bit arc, bit fl, bit dir, logic [15:0] x, logic [15:0] y,
                         logic [15:0] d);
        valid_out = v; arctan_en_out = arc; flip_out = fl; flip_dir_out = dir;
        x_out = x; y_out = y; degree_out = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        ready_in_interface = 1'b1;
        do_reset();
        checks++;
        if (valid_out_interface !== 1'b0 || out_interface !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got v=%b w=%h want v=0 w=0", valid_out_interface,
                     out_interface);
        end
        checks++;
        if (fifo_count !== 3'd0 || overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d ovf=%b want 0 0", fifo_count, overflow_flag);
        end
    endtask

    task automatic test_reset_mid_transfer();
        ready_in_interface = 1'b0;
        drive(1, 0, 0, 0, 16'h1111, 16'h2222, 16'h0);
        step();
        drive(1, 1, 0, 0, 16'h0, 16'h0, 16'h0033);
        step();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        checks++;
        if (valid_out_interface !== 1'b1) begin
            errors++;
            $display("FAIL mid_valid: got %b want 1", valid_out_interface);
        end
        do_reset();
        checks++;
        if (valid_out_interface !== 1'b0 || out_interface !== 32'h0 ||
            fifo_count !== 3'd0 || overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b w=%h cnt=%0d ovf=%b want 0 0 0 0",
                     valid_out_interface, out_interface, fifo_count, overflow_flag);
        end
        ready_in_interface = 1'b1;
    endtask

    // Pushes one result, then expects the listed words on consecutive cycles and idle after.
    task automatic expect_words(string name, logic [31:0] w0, logic [31:0] w1, int n);
        logic [31:0] exp_w;
        step();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < n; i++) begin
            step();
            exp_w = (i == 0) ? w0 : w1;
            checks++;
            if (valid_out_interface !== 1'b1 || out_interface !== exp_w) begin
                errors++;
                $display("FAIL %s_w%0d: got v=%b w=%h want v=1 w=%h", name, i,
                         valid_out_interface, out_interface, exp_w);
            end
        end
        step();
        checks++;
        if (valid_out_interface !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got v=%b want 0", name, valid_out_interface);
        end
    endtask

    task automatic test_arctan();
        ready_in_interface = 1'b1;
        drive(1, 1, 1, 1, 16'h1234, 16'h5678, 16'sd45);
        expect_words("arctan", 32'h0001_002D, 32'h0, 1);
    endtask

    task automatic test_rotation();
        drive(1, 0, 0, 0, 16'h00DD, 16'h0080, 16'h0);
        expect_words("rot", 32'h0000_00DD, 32'h0002_0080, 2);
    endtask

    task automatic test_fold();
        drive(1, 0, 1, 1, 16'h0080, 16'h00DD, 16'h0);
        expect_words("fold_pos", 32'h0000_FF23, 32'h0002_0080, 2);
        drive(1, 0, 1, 0, 16'h8000, 16'h1234, 16'h0);
        expect_words("fold_sat", 32'h0000_1234, 32'h0002_7FFF, 2);
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        do_reset();
        ready_in_interface = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 16'h0, 16'h0, 16'(16'h0100 + i));
            step();
        end
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        checks++;
        if (fifo_count !== 3'd4 || overflow_flag !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: got cnt=%0d ovf=%b want 4 1", fifo_count, overflow_flag);
        end
        held = out_interface;
        checks++;
        if (held !== 32'h0001_0100) begin
            errors++;
            $display("FAIL bp_head: got %h want 00010100", held);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (out_interface !== held || valid_out_interface !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable: got v=%b w=%h want v=1 w=%h", valid_out_interface,
                     out_interface, held);
        end
        ready_in_interface = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            checks++;
            if (valid_out_interface !== 1'b1 || out_interface !== 32'(32'h0001_0100 + i)) begin
                errors++;
                $display("FAIL bp_drain%0d: got v=%b w=%h want v=1 w=%h", i,
                         valid_out_interface, out_interface, 32'(32'h0001_0100 + i));
            end
        end
        step();
        checks++;
        if (valid_out_interface !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL bp_empty: got v=%b cnt=%0d want 0 0", valid_out_interface, fifo_count);
        end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        ready_in_interface = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 16'h0, 16'h0, 16'(16'h0200 + i));
            step();
        end
        checks++;
        if (fifo_count !== 3'd4 || overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL ppf_pre: got cnt=%0d ovf=%b want 4 0", fifo_count, overflow_flag);
        end
        ready_in_interface = 1'b1;
        drive(1, 1, 0, 0, 16'h0, 16'h0, 16'h0299);
        step();
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        checks++;
        if (fifo_count !== 3'd4 || overflow_flag !== 1'b0 || out_interface !== 32'h0001_0201) begin
            errors++;
            $display("FAIL ppf_post: got cnt=%0d ovf=%b w=%h want 4 0 00010201", fifo_count,
                     overflow_flag, out_interface);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (out_interface !== 32'h0001_0299) begin
            errors++;
            $display("FAIL ppf_last: got %h want 00010299", out_interface);
        end
    endtask

    task automatic test_random();
        logic [31:0] prev_out;
        bit          prev_stall;
        do_reset();
        prev_stall = 0;
        prev_out   = '0;
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 9) < 6), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom));
            ready_in_interface = ($urandom_range(0, 9) < 6);
            prev_stall = valid_out_interface && !ready_in_interface;
            prev_out   = out_interface;
            step();
            checks++;
            if (valid_out_interface !== m_valid || (m_valid && out_interface !== m_out)) begin
                errors++;
                $display("FAIL rand_word@%0d: got v=%b w=%h want v=%b w=%h", c,
                         valid_out_interface, out_interface, m_valid, m_out);
            end
            checks++;
            if (fifo_count !== 3'(q.size()) || overflow_flag !== m_ovf) begin
                errors++;
                $display("FAIL rand_state@%0d: got cnt=%0d ovf=%b want %0d %b", c, fifo_count,
                         overflow_flag, q.size(), m_ovf);
            end
            if (prev_stall) begin
                checks++;
                if (out_interface !== prev_out) begin
                    errors++;
                    $display("FAIL rand_hold@%0d: got %h want %h", c, out_interface, prev_out);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ready_in_interface = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        test_reset();
        test_arctan();
        test_rotation();
        test_fold();
        test_reset_mid_transfer();
        test_backpressure();
        test_push_pop_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
